// File: rtl/kalman_tx_ctrl_if.sv
// Filter-sample input and serializer-load output bundle for kalman_tx_ctrl.
// master drives samples and consumes tx pulses; slave is the controller.
interface kalman_tx_ctrl_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] filt_data;
    logic              filt_valid;
    logic [DATA_W-1:0] tx_data;
    logic              tx_load;
    logic              frame_done;
    logic              frame_abort;

    modport master (
        output filt_data, filt_valid,
        input  tx_data, tx_load, frame_done, frame_abort
    );

    modport slave (
        input  filt_data, filt_valid,
        output tx_data, tx_load, frame_done, frame_abort
    );
endinterface

// File: rtl/kalman_tx_ctrl.sv
// Buffers Kalman filter samples and hands one word per Pi SPI frame to the serializer.
// Optional KALMAN_TX_OVR_COUNT_EN adds a saturating dropped-sample counter ovr_count.
module kalman_tx_ctrl #(
    parameter int DATA_W      = 16,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    kalman_tx_ctrl_if.slave              bus,
    input  logic                         rpi_cs,
    input  logic                         rpi_sck,
    input  logic                         clr_flags,
    output logic                         busy,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
    output logic                         overrun,
    output logic                         underrun
`ifdef KALMAN_TX_OVR_COUNT_EN
    ,
    output logic [7:0]                   ovr_count
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, WAIT_CS} state_t;

    state_t              state;
    logic [CW-1:0]       bit_cnt;
    logic [DATA_W-1:0]   tx_data;
    logic                tx_load;
    logic                frame_done;
    logic                frame_abort;
    logic                frame_empty;

    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES:0]   fill;
    logic                   cs_prev;
    logic                   sck_prev;
    logic                   cs_fall;
    logic                   cs_rise;
    logic                   sck_rise;

    logic [DATA_W-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic                full;
    logic                empty;
    logic                pop;
    logic                push;
    logic                drop;
    logic                under_set;

    assign bus.tx_data     = tx_data;
    assign bus.tx_load     = tx_load;
    assign bus.frame_done  = frame_done;
    assign bus.frame_abort = frame_abort;

    // Edges are suppressed until the chains hold real pin samples after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_sync  <= '1;
            sck_sync <= '0;
            cs_prev  <= 1'b1;
            sck_prev <= 1'b0;
            fill     <= '0;
            cs_fall  <= 1'b0;
            cs_rise  <= 1'b0;
            sck_rise <= 1'b0;
        end else begin
            cs_sync  <= {cs_sync[SYNC_STAGES-2:0], rpi_cs};
            sck_sync <= {sck_sync[SYNC_STAGES-2:0], rpi_sck};
            cs_prev  <= cs_sync[SYNC_STAGES-1];
            sck_prev <= sck_sync[SYNC_STAGES-1];
            fill     <= {fill[SYNC_STAGES-1:0], 1'b1};
            cs_fall  <= fill[SYNC_STAGES] & cs_prev & ~cs_sync[SYNC_STAGES-1];
            cs_rise  <= fill[SYNC_STAGES] & ~cs_prev & cs_sync[SYNC_STAGES-1];
            sck_rise <= fill[SYNC_STAGES] & ~sck_prev & sck_sync[SYNC_STAGES-1];
        end
    end

    assign full      = (fifo_level == LW'(FIFO_DEPTH));
    assign empty     = (fifo_level == '0);
    assign pop       = frame_done & ~frame_empty & ~empty;
    assign push      = bus.filt_valid & (~full | pop);
    assign drop      = bus.filt_valid & full & ~pop;
    assign under_set = (state == LOAD) & empty;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= bus.filt_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                fifo_level <= fifo_level + 1'b1;
            else if (pop && !push)
                fifo_level <= fifo_level - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun  <= 1'b0;
            underrun <= 1'b0;
        end else begin
            if (drop)
                overrun <= 1'b1;
            else if (clr_flags)
                overrun <= 1'b0;
            if (under_set)
                underrun <= 1'b1;
            else if (clr_flags)
                underrun <= 1'b0;
        end
    end

`ifdef KALMAN_TX_OVR_COUNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ovr_count <= '0;
        else if (drop) begin
            if (ovr_count != 8'hFF)
                ovr_count <= ovr_count + 8'd1;
        end else if (clr_flags)
            ovr_count <= '0;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            tx_data     <= '0;
            tx_load     <= 1'b0;
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;
            frame_empty <= 1'b0;
            busy        <= 1'b0;
        end else begin
            tx_load     <= 1'b0;
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;
            case (state)
                IDLE: begin
                    if (cs_fall)
                        state <= LOAD;
                end
                LOAD: begin
                    tx_data     <= empty ? '0 : mem[rd_ptr];
                    frame_empty <= empty;
                    tx_load     <= 1'b1;
                    bit_cnt     <= '0;
                    busy        <= 1'b1;
                    state       <= SHIFT;
                end
                SHIFT: begin
                    // Abort leaves the head in place so the word is resent.
                    if (cs_rise) begin
                        frame_abort <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else if (sck_rise) begin
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == CW'(DATA_W - 1)) begin
                            frame_done <= 1'b1;
                            state      <= WAIT_CS;
                        end
                    end
                end
                WAIT_CS: begin
                    if (cs_rise) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
